// File: rtl/ram_bus_pkg.sv
// Shared types and default widths for the single-port RAM bus initiator.
package ram_bus_pkg;

  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_LEN_WIDTH  = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    READ    = 3'd2,
    CAPTURE = 3'd3,
    TURN    = 3'd4
  } state_t;

  // Chip select is held through every state that touches the RAM.
  function automatic logic state_selects_ram(input state_t s);
    return (s == WRITE) || (s == READ) || (s == CAPTURE);
  endfunction

  // Output enable covers the read address phase and the capture phase.
  function automatic logic state_enables_output(input state_t s);
    return (s == READ) || (s == CAPTURE);
  endfunction

endpackage

// File: rtl/ram_bus_master.sv
// Initiator for the single-port synchronous RAM bus: single-word writes and
// auto-incrementing read bursts, every output registered.
module ram_bus_master
  import ram_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [LEN_WIDTH-1:0]  req_len,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_last,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  inout  wire  [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_chip_select,
  output logic                  ram_write_enable,
  output logic                  ram_output_enable
);

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
  logic [LEN_WIDTH-1:0]  beats_left_reg, beats_left_next;

  logic                  req_ready_reg, req_ready_next;
  logic                  rsp_valid_reg, rsp_valid_next;
  logic                  rsp_last_reg, rsp_last_next;
  logic [DATA_WIDTH-1:0] rsp_rdata_reg, rsp_rdata_next;
  logic [ADDR_WIDTH-1:0] ram_addr_reg, ram_addr_next;
  logic                  cs_reg, cs_next;
  logic                  we_reg, we_next;
  logic                  oe_reg, oe_next;
  logic                  drive_en_reg, drive_en_next;

  logic accept;
  assign accept = req_valid && req_ready_reg;

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      beats_left_reg <= '0;
      req_ready_reg  <= 1'b0;
      rsp_valid_reg  <= 1'b0;
      rsp_last_reg   <= 1'b0;
      rsp_rdata_reg  <= '0;
      ram_addr_reg   <= '0;
      cs_reg         <= 1'b0;
      we_reg         <= 1'b0;
      oe_reg         <= 1'b0;
      drive_en_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      beats_left_reg <= beats_left_next;
      req_ready_reg  <= req_ready_next;
      rsp_valid_reg  <= rsp_valid_next;
      rsp_last_reg   <= rsp_last_next;
      rsp_rdata_reg  <= rsp_rdata_next;
      ram_addr_reg   <= ram_addr_next;
      cs_reg         <= cs_next;
      we_reg         <= we_next;
      oe_reg         <= oe_next;
      drive_en_reg   <= drive_en_next;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_next      = state_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    beats_left_next = beats_left_reg;
    unique case (state_reg)
      IDLE: begin
        if (accept) begin
          addr_next       = req_addr;
          wdata_next      = req_wdata;
          beats_left_next = req_len;
          state_next      = req_write ? WRITE : READ;
        end
      end
      WRITE:   state_next = IDLE;
      READ:    state_next = CAPTURE;
      CAPTURE: begin
        if (beats_left_reg != '0) begin
          // Address wraps naturally at the top of the RAM.
          addr_next       = addr_reg + ADDR_WIDTH'(1);
          beats_left_next = beats_left_reg - LEN_WIDTH'(1);
          state_next      = READ;
        end else begin
          state_next = TURN;
        end
      end
      TURN:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so the registered pins line
  // up with the state they belong to.
  always_comb begin
    req_ready_next = (state_next == IDLE);
    cs_next        = state_selects_ram(state_next);
    we_next        = (state_next == WRITE);
    oe_next        = state_enables_output(state_next);
    drive_en_next  = (state_next == WRITE);
    ram_addr_next  = addr_next;
    rsp_valid_next = (state_reg == CAPTURE);
    rsp_last_next  = (state_reg == CAPTURE) && (beats_left_reg == '0);
    rsp_rdata_next = (state_reg == CAPTURE) ? ram_data : rsp_rdata_reg;
  end

  assign ram_data = drive_en_reg ? wdata_reg : {DATA_WIDTH{1'bz}};

  assign req_ready         = req_ready_reg;
  assign rsp_valid         = rsp_valid_reg;
  assign rsp_last          = rsp_last_reg;
  assign rsp_rdata         = rsp_rdata_reg;
  assign ram_addr          = ram_addr_reg;
  assign ram_chip_select   = cs_reg;
  assign ram_write_enable  = we_reg;
  assign ram_output_enable = oe_reg;

endmodule

// File: tb/tb_ram_bus_master.sv
// Directed bench for ram_bus_master with a behavioural synchronous RAM on the bus.
module tb_ram_bus_master;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_write = 1'b0;
  logic [9:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic [3:0] req_len = '0;
  wire        req_ready, rsp_valid, rsp_last;
  wire  [7:0] rsp_rdata;
  wire  [9:0] ram_addr;
  wire  [7:0] ram_data;
  wire        cs, we, oe;

  int tests = 0;
  int failures = 0;
  int contention_errs = 0;

  logic [7:0] shadow [0:1023];
  logic [7:0] mem [0:1023];
  logic [7:0] ram_q = '0;

  always #5 clk = ~clk;

  ram_bus_master dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_last(rsp_last),
    .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_chip_select(cs), .ram_write_enable(we), .ram_output_enable(oe)
  );

  // Single-port synchronous RAM: commits writes and registers reads on the edge.
  always @(posedge clk) begin
    if (cs) begin
      if (we) mem[ram_addr] <= ram_data;
      else    ram_q <= mem[ram_addr];
    end
  end
  assign ram_data = (cs && oe && !we) ? ram_q : 8'bz;

  always @(negedge clk) begin
    if (!rst && dut.drive_en_reg && cs && oe && !we) contention_errs <= contention_errs + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic issue(input logic wr, input logic [9:0] a, input logic [7:0] d, input int len);
    int n;
    n = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) begin
      tests++; failures++;
      $display("FAIL issue_timeout: req_ready=%b after %0d cycles, required 1", req_ready, n);
    end
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_len = 4'(len);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic do_write(input logic [9:0] a, input logic [7:0] d);
    issue(1'b1, a, d, 0);
    shadow[a] = d;
    tests++;
    if (cs !== 1'b1 || we !== 1'b1 || oe !== 1'b0 || ram_addr !== a || ram_data !== d) begin
      failures++;
      $display("FAIL write_cycle: cs=%b we=%b oe=%b addr=%0d data=%h, required 1 1 0 %0d %h",
               cs, we, oe, ram_addr, ram_data, a, d);
    end
    @(posedge clk); #1;
    tests++;
    if (req_ready !== 1'b1 || cs !== 1'b0 || we !== 1'b0) begin
      failures++;
      $display("FAIL write_done: ready=%b cs=%b we=%b, required 1 0 0", req_ready, cs, we);
    end
  endtask

  // Cycle c counts from the acceptance edge: READ for beat k at c=2k,
  // response for beat k at c=2k+2, TURN at c=2*len+2, ready at c=2*len+3.
  task automatic do_read(input logic [9:0] a, input int len);
    logic [9:0] ea;
    logic [7:0] ed;
    int beat;
    issue(1'b0, a, 8'h00, len);
    for (int c = 0; c <= 2 * len + 3; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (c % 2 == 0 && c <= 2 * len) begin
        ea = a + 10'(c / 2);
        tests++;
        if (ram_addr !== ea || cs !== 1'b1 || oe !== 1'b1 || we !== 1'b0) begin
          failures++;
          $display("FAIL read_addr beat %0d: addr=%0d cs=%b oe=%b we=%b, required %0d 1 1 0",
                   c / 2, ram_addr, cs, oe, we, ea);
        end
      end
      if (c >= 2 && c % 2 == 0) begin
        beat = c / 2 - 1;
        ea = a + 10'(beat);
        ed = shadow[ea];
        tests++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== ed || rsp_last !== (beat == len)) begin
          failures++;
          $display("FAIL read_rsp beat %0d: valid=%b data=%h last=%b, required 1 %h %b",
                   beat, rsp_valid, rsp_rdata, rsp_last, ed, (beat == len));
        end
      end else begin
        tests++;
        if (rsp_valid !== 1'b0) begin
          failures++;
          $display("FAIL read_gap c=%0d: rsp_valid=%b, required 0", c, rsp_valid);
        end
      end
      if (c == 2 * len + 2) begin
        tests++;
        if (cs !== 1'b0 || oe !== 1'b0 || dut.drive_en_reg !== 1'b0) begin
          failures++;
          $display("FAIL read_turn: cs=%b oe=%b drive=%b, required 0 0 0", cs, oe, dut.drive_en_reg);
        end
      end
      if (c == 2 * len + 3) begin
        tests++;
        if (req_ready !== 1'b1) begin
          failures++;
          $display("FAIL read_ready: req_ready=%b, required 1", req_ready);
        end
      end
    end
  endtask

  task automatic check_reset_outputs(input string name);
    tests++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_last !== 1'b0 || rsp_rdata !== 8'h00 ||
        cs !== 1'b0 || we !== 1'b0 || oe !== 1'b0 || ram_addr !== 10'd0 || dut.drive_en_reg !== 1'b0) begin
      failures++;
      $display("FAIL %s: ready=%b valid=%b last=%b rdata=%h cs=%b we=%b oe=%b addr=%0d drive=%b, required all 0",
               name, req_ready, rsp_valid, rsp_last, rsp_rdata, cs, we, oe, ram_addr, dut.drive_en_reg);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_hold");
    rst = 1'b0;
    #1;
    tests++;
    if (req_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: req_ready=%b before first edge, required 0", req_ready);
    end
    @(posedge clk); #1;
    tests++;
    if (req_ready !== 1'b1 || cs !== 1'b0 || oe !== 1'b0 || dut.drive_en_reg !== 1'b0) begin
      failures++;
      $display("FAIL reset_first_edge: ready=%b cs=%b oe=%b drive=%b, required 1 0 0 0",
               req_ready, cs, oe, dut.drive_en_reg);
    end
  endtask

  task automatic test_single();
    do_write(10'd5, 8'hA3);
    do_read(10'd5, 0);
  endtask

  task automatic test_burst();
    for (int i = 0; i < 16; i++) do_write(10'(i), 8'(i) ^ 8'h5A);
    do_read(10'd0, 15);
  endtask

  task automatic test_wrap();
    do_write(10'd1022, 8'h11);
    do_write(10'd1023, 8'h22);
    do_write(10'd0, 8'h33);
    do_read(10'd1022, 2);
  endtask

  task automatic test_back_to_back();
    do_read(10'd1023, 0);
    do_write(10'd200, 8'hC4);
    do_read(10'd200, 0);
  endtask

  task automatic test_bus_check();
    tests++;
    if (contention_errs !== 0) begin
      failures++;
      $display("FAIL bus_contention: %0d overlapping-drive cycles, required 0", contention_errs);
    end
  endtask

  task automatic test_reset_mid_burst();
    int stray;
    stray = 0;
    issue(1'b0, 10'd0, 8'h00, 7);
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check_reset_outputs("reset_mid_burst");
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) stray++;
    end
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) stray++;
    end
    tests++;
    if (stray != 0) begin
      failures++;
      $display("FAIL reset_abandon: %0d rsp_valid cycles after reset, required 0", stray);
    end
    do_write(10'd9, 8'h7E);
    do_read(10'd9, 0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_wrap();
    test_back_to_back();
    test_reset_mid_burst();
    test_bus_check();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/ram_bus_master.md
Name: ram_bus_master

Overview:
- Initiator for the single_port_sync_ram bus (chip_select / write_enable / output_enable, shared tri-state data).
- Accepts word requests on a valid/ready interface and sequences the RAM control pins cycle-accurately.
- Drives write data onto the shared bus and captures read data, including auto-incrementing read bursts.
- Sits between any on-chip requester (CPU load/store unit, DMA) and the RAM instance.

Parameters:
- ADDR_WIDTH, 10, RAM address width.
- DATA_WIDTH, 8, RAM data width.
- LEN_WIDTH, 4, burst length field width.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request this cycle.
- req_write  in  1  1 = single-word write, 0 = read burst.
- req_addr  in  ADDR_WIDTH  start address.
- req_wdata  in  DATA_WIDTH  write data (writes only).
- req_len  in  LEN_WIDTH  read beats minus one (0 = 1 beat, 15 = 16 beats); ignored for writes.
- rsp_valid  out  1  one-cycle pulse per returned read word.
- rsp_rdata  out  DATA_WIDTH  read word, valid with rsp_valid.
- rsp_last  out  1  marks final beat of a burst, valid with rsp_valid.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_data  inout  DATA_WIDTH  shared RAM data bus.
- ram_chip_select  out  1  RAM chip select.
- ram_write_enable  out  1  RAM write enable.
- ram_output_enable  out  1  RAM output enable; controller drives ram_data only while this is 0.

Behaviour:
- Reset values (immediate on rst, asynchronous):
  - state = IDLE.
  - req_ready = 0; set to 1 on the first clk edge after release.
  - rsp_valid = 0, rsp_last = 0, rsp_rdata = 0.
  - ram_chip_select = 0, ram_write_enable = 0, ram_output_enable = 0, ram_addr = 0.
  - Bus driver disabled; ram_data = 'z from this block.
- Reset mid-burst: burst is abandoned; no further rsp_valid.
- All outputs are registered. The bus driver enable is a registered flop, asserted only in WRITE.
- Acceptance: a request is accepted on an edge where req_valid & req_ready. req_ready = 1 only in IDLE and drops on the accepting edge.
- States:
  - IDLE -> WRITE when accepting with req_write = 1.
  - IDLE -> READ when accepting with req_write = 0. Latch addr, wdata and beats_left = req_len.
  - WRITE, 1 cycle: cs = 1, we = 1, oe = 0, ram_addr = addr, ram_data driven = wdata. RAM commits on the edge ending WRITE. Next state IDLE.
  - READ, 1 cycle: cs = 1, we = 0, oe = 1, ram_addr = addr. RAM samples the address on the edge ending READ.
  - CAPTURE, 1 cycle: cs = 1, we = 0, oe = 1. ram_data is sampled into rsp_rdata on the edge ending CAPTURE. rsp_valid = 1 in the following cycle; rsp_last = (beats_left == 0).
    - If beats_left != 0: addr <= addr + 1 (wraps mod 2^ADDR_WIDTH, 1023 -> 0), beats_left decrements, next state READ.
    - Otherwise next state TURN.
  - TURN, 1 cycle: cs = 0, oe = 0, driver off. Bus turnaround. Next state IDLE.
- Latency:
  - Write: 2 cycles from acceptance to req_ready high again.
  - Read beat: 2 cycles per beat; first rsp_valid 3 edges after acceptance.
  - Burst of N beats returns N rsp_valid pulses spaced 2 cycles apart.
- No contention, by construction: the controller drives only in WRITE (oe = 0); the RAM drives only when cs & oe & !we.
- Responses have no backpressure; the consumer must accept every rsp_valid pulse.
- req_valid while busy is held off by req_ready = 0. Request fields are don't-care when req_valid = 0.

Decomposition:
- Shared package ram_bus_pkg:
  - state enum (IDLE, WRITE, READ, CAPTURE, TURN).
  - default width constants: ADDR_WIDTH 10, DATA_WIDTH 8, LEN_WIDTH 4.
- No sub-module required.
- Tri-state driver is a single continuous assign gated by the registered drive-enable flop.

Test Plan:
- Reset release: req_ready goes 0 -> 1 one edge after rst falls; cs = 0, oe = 0, ram_data = z.
- Write addr 5 data 8'hA3, then read addr 5 len 0: one rsp_valid with rdata = 8'hA3 and rsp_last = 1, 3 edges after read acceptance.
- Write addr 0..15 with data i^8'h5A, then read addr 0 len 15: 16 rsp_valid pulses 2 cycles apart, matching data, rsp_last only on beat 16.
- Wrap: preload 1022, 1023, 0 with 8'h11, 8'h22, 8'h33; read addr 1022 len 2: responses 8'h11, 8'h22, 8'h33, with ram_addr sequence 1022, 1023, 0.
- Bus check: assert every cycle that the controller drive enable and (cs & oe & !we) are never both 1; TURN shows cs = 0 between read and write.
- rst asserted during beat 3 of a len 7 burst: outputs reset immediately, no further rsp_valid; a subsequent write/read of addr 9 with 8'h7E returns 8'h7E.
